// File: rtl/sifh_frame_sequencer.sv
// sifh_frame_sequencer: feeds one SiFH frame (coarse then fine pass) into the serial
// histogram builder, clearing it first and draining its pipeline after each pass.
module sifh_frame_sequencer #(
  parameter int NP = 12,
  parameter int NB = 6,
  parameter int PIXEL_NUM = 4,
  parameter int DATA_NUM = 2,
  parameter int ACQ_NUM = 8,
  parameter int CLR_CYCLES = 2,
  parameter int DRAIN_CYCLES = 4,
  localparam int PW = PIXEL_NUM > 1 ? $clog2(PIXEL_NUM) : 1,
  localparam int AW = ACQ_NUM > 1 ? $clog2(ACQ_NUM) : 1
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic          abort,
  input  logic          ts_valid,
  input  logic [NP-1:0] ts_data,
  output logic          ts_ready,
  output logic          hb_wrEn,
  output logic [NP-1:0] hb_data,
  output logic          hb_res,
  output logic          pass,
  output logic [PW-1:0] pixel_idx,
  output logic [AW-1:0] acq_idx,
  output logic          busy,
  output logic          frame_done
);
  localparam int SW = DATA_NUM > 1 ? $clog2(DATA_NUM) : 1;
  localparam int CM = CLR_CYCLES > DRAIN_CYCLES ? CLR_CYCLES : DRAIN_CYCLES;
  localparam int CW = CM > 1 ? $clog2(CM) : 1;
  if (NB > NP) begin : g_bad_nb
    $error("NB must not exceed NP");
  end
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;
  state_t        state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [AW-1:0] acq_q, acq_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NP-1:0] hb_data_q, hb_data_d;
  logic          pass_q, pass_d, wr_en_q, wr_en_d, hb_res_q, hb_res_d;
  logic          hs, last_slot, last_pix, last_acq;
  assign last_slot = slot_q == SW'(DATA_NUM - 1);
  assign last_pix  = pix_q == PW'(PIXEL_NUM - 1);
  assign last_acq  = acq_q == AW'(ACQ_NUM - 1);
  // abort masks ready so an aborted cycle never reaches the builder
  assign ts_ready  = state_q == STREAM && !abort;
  assign hs        = ts_valid && ts_ready;
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    pix_d     = pix_q;
    acq_d     = acq_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    wr_en_d   = hs;
    hb_data_d = hs ? ts_data : hb_data_q;
    if (abort) begin
      state_d = IDLE;
      slot_d  = '0;
      pix_d   = '0;
      acq_d   = '0;
      cnt_d   = '0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = CLEAR;
          slot_d  = '0;
          pix_d   = '0;
          acq_d   = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
        CLEAR: begin
          cnt_d   = cnt_q == CW'(CLR_CYCLES - 1) ? '0 : cnt_q + 1'b1;
          state_d = cnt_q == CW'(CLR_CYCLES - 1) ? STREAM : CLEAR;
        end
        STREAM: if (hs) begin
          slot_d  = last_slot ? '0 : slot_q + 1'b1;
          pix_d   = !last_slot ? pix_q : last_pix ? '0 : pix_q + 1'b1;
          acq_d   = !(last_slot && last_pix) ? acq_q : last_acq ? '0 : acq_q + 1'b1;
          cnt_d   = '0;
          state_d = last_slot && last_pix && last_acq ? DRAIN : STREAM;
        end
        DRAIN: if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
          cnt_d   = '0;
          pass_d  = 1'b1;
          state_d = pass_q ? DONE : STREAM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        DONE: begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
    hb_res_d = state_d != CLEAR;
  end
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      pix_q     <= '0;
      acq_q     <= '0;
      cnt_q     <= '0;
      pass_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      hb_data_q <= '0;
      hb_res_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      pix_q     <= pix_d;
      acq_q     <= acq_d;
      cnt_q     <= cnt_d;
      pass_q    <= pass_d;
      wr_en_q   <= wr_en_d;
      hb_data_q <= hb_data_d;
      hb_res_q  <= hb_res_d;
    end
  end
  assign hb_wrEn    = wr_en_q;
  assign hb_data    = hb_data_q;
  assign hb_res     = hb_res_q;
  assign pass       = pass_q;
  assign pixel_idx  = pix_q;
  assign acq_idx    = acq_q;
  assign busy       = state_q != IDLE;
  assign frame_done = state_q == DONE;
endmodule

// File: tb/tb_sifh_frame_sequencer.sv
// tb_sifh_frame_sequencer: random-stimulus bench checking the frame sequencer against a
// word-count model of the builder's acquisition/pixel/slot order.
module tb_sifh_frame_sequencer;
  localparam int DN = 2;
  localparam int PN = 4;
  localparam int WORDS = 64;
  logic clk = 1'b0, res = 1'b0, start = 1'b0, abort = 1'b0, ts_valid = 1'b0;
  logic [11:0] ts_data = '0;
  logic ts_ready, hb_wrEn, hb_res, pass, busy, frame_done;
  logic [11:0] hb_data;
  logic [1:0] pixel_idx;
  logic [2:0] acq_idx;
  int cmp = 0, errs = 0;
  int k_m = 0, res_low, drain_n, done_n;
  int wr_n[2];
  bit pass_m = 1'b0;

  always #5 clk = ~clk;

  sifh_frame_sequencer dut (
    .clk(clk), .res(res), .start(start), .abort(abort), .ts_valid(ts_valid),
    .ts_data(ts_data), .ts_ready(ts_ready), .hb_wrEn(hb_wrEn), .hb_data(hb_data),
    .hb_res(hb_res), .pass(pass), .pixel_idx(pixel_idx), .acq_idx(acq_idx),
    .busy(busy), .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit v, input logic [11:0] d, input bit st, input bit ab);
    bit hs;
    @(negedge clk);
    ts_valid = v; ts_data = d; start = st; abort = ab;
    #1;
    if (busy && !ts_ready && hb_res && !frame_done) drain_n++;
    if (!hb_res) res_low++;
    if (frame_done) done_n++;
    hs = v && ts_ready && !ab;
    if (hs) begin
      chk("pixel_idx", pixel_idx, (k_m / DN) % PN);
      chk("acq_idx", acq_idx, k_m / (DN * PN));
      chk("pass", pass, pass_m);
      k_m++;
      if (k_m == WORDS) begin
        k_m = 0;
        pass_m = !pass_m;
      end
    end
    @(posedge clk); #1;
    chk("hb_wrEn", hb_wrEn, hs);
    if (hs) chk("hb_data", hb_data, d);
    if (hb_wrEn) wr_n[pass]++;
  endtask

  // mode 0: data = slot index; mode 1: odd slots all-ones, even slots random
  task automatic run_frame(input int mode, input bit gaps, input bit st_noise, input int abort_k);
    bit v, st;
    logic [11:0] d;
    res_low = 0; drain_n = 0; done_n = 0; wr_n[0] = 0; wr_n[1] = 0;
    k_m = 0; pass_m = 1'b0;
    cycle(1'b0, 12'h0, 1'b1, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      d = mode == 0 ? 12'(k_m % 2) : (k_m % 2 == 1 ? 12'hFFF : 12'($urandom));
      if (abort_k >= 0 && pass_m && k_m == abort_k) begin
        cycle(1'b1, d, 1'b0, 1'b1);
        break;
      end
      v = gaps ? 1'($urandom % 2) : 1'b1;
      st = st_noise && ($urandom % 4 == 0);
      cycle(v, d, st, 1'b0);
      if (done_n != 0) break;
    end
  endtask

  initial begin
    #3;
    chk("rst_hb_res", hb_res, 0);
    chk("rst_hb_wrEn", hb_wrEn, 0);
    chk("rst_hb_data", hb_data, 0);
    chk("rst_ts_ready", ts_ready, 0);
    chk("rst_pass", pass, 0);
    chk("rst_pixel_idx", pixel_idx, 0);
    chk("rst_acq_idx", acq_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    #20 res = 1'b1;
    repeat (3) cycle(1'b1, 12'h5A5, 1'b0, 1'b0);
    chk("idle_busy", busy, 0);
    chk("idle_hb_res", hb_res, 1);

    run_frame(0, 1'b0, 1'b0, -1);
    chk("f1_clear_cycles", res_low, 2);
    chk("f1_wr_pass0", wr_n[0], WORDS);
    chk("f1_wr_pass1", wr_n[1], WORDS);
    chk("f1_drain_cycles", drain_n, 8);
    chk("f1_done", done_n, 1);
    repeat (2) cycle(1'b0, 12'h0, 1'b0, 1'b0);
    chk("f1_busy_after", busy, 0);
    chk("f1_pass_after", pass, 0);
    chk("f1_done_after", frame_done, 0);

    run_frame(0, 1'b1, 1'b0, -1);
    chk("gap_wr_pass0", wr_n[0], WORDS);
    chk("gap_wr_pass1", wr_n[1], WORDS);
    chk("gap_done", done_n, 1);

    run_frame(1, 1'b1, 1'b0, -1);
    chk("ones_wr_pass0", wr_n[0], WORDS);
    chk("ones_wr_pass1", wr_n[1], WORDS);
    chk("ones_done", done_n, 1);

    run_frame(0, 1'b0, 1'b0, 29);
    chk("abort_busy", busy, 0);
    chk("abort_ts_ready", ts_ready, 0);
    chk("abort_pass", pass, 0);
    chk("abort_pixel_idx", pixel_idx, 0);
    chk("abort_acq_idx", acq_idx, 0);
    k_m = 0; pass_m = 1'b0;
    repeat (5) cycle(1'b1, 12'h123, 1'b0, 1'b0);
    chk("abort_no_done", done_n, 0);
    run_frame(0, 1'b0, 1'b0, -1);
    chk("reuse_clear_cycles", res_low, 2);
    chk("reuse_done", done_n, 1);

    run_frame(1, 1'b1, 1'b1, -1);
    chk("noise_wr_pass0", wr_n[0], WORDS);
    chk("noise_wr_pass1", wr_n[1], WORDS);
    chk("noise_done", done_n, 1);
    repeat (2) cycle(1'b0, 12'h0, 1'b0, 1'b0);
    chk("noise_busy_after", busy, 0);

    k_m = 0; pass_m = 1'b0;
    cycle(1'b0, 12'h0, 1'b1, 1'b0);
    repeat (20) cycle(1'b1, 12'($urandom), 1'b0, 1'b0);
    #2 res = 1'b0;
    #1;
    chk("ares_hb_res", hb_res, 0);
    chk("ares_hb_wrEn", hb_wrEn, 0);
    chk("ares_hb_data", hb_data, 0);
    chk("ares_ts_ready", ts_ready, 0);
    chk("ares_pass", pass, 0);
    chk("ares_pixel_idx", pixel_idx, 0);
    chk("ares_acq_idx", acq_idx, 0);
    chk("ares_busy", busy, 0);
    #3 res = 1'b1;
    k_m = 0; pass_m = 1'b0; done_n = 0;
    repeat (4) cycle(1'b1, 12'h3C3, 1'b0, 1'b0);
    chk("ares_idle_busy", busy, 0);
    chk("ares_idle_ready", ts_ready, 0);
    chk("ares_idle_done", done_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
